bc_control_unit: RTL
====================

Name: bc_control_unit

Overview:
- Timing-and-control sequencer for the 16-bit basic computer.
- Drives the ALU opcode select and consumes the ALU flags and E-control (CNTRL_E) outputs.
- Generates every register load/inc/clear strobe, bus select and memory strobe for fetch, decode, indirect and execute (memory-reference and register-reference).
- Sits between the IR/flag sources and the datapath registers.

Parameters:
- WIDTH, 16, datapath word width; opcode field is always ir[WIDTH-2:WIDTH-4], I bit is ir[WIDTH-1].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ir  in  WIDTH  current IR contents.
- ac_n  in  1  ALU N flag (AC sign).
- ac_z  in  1  ALU Z flag (AC==0).
- dr_z  in  1  DR==0.
- e  in  1  current E flip-flop.
- cntrl_e  in  2  ALU E control: 10 = set E, 01 = clear E, 00/11 = no change.
- opsel  out  3  ALU op: 000 ADD, 001 AND, 010 pass DR, 011 complement AC, 100 shift right through E, 101 shift left through E.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 MEM.
- ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ac_clr, ac_inc, ir_ld  out  1 each  register strobes.
- mem_rd, mem_wr  out  1 each  memory strobes.
- e_set, e_clr, e_cmp  out  1 each  E control.
- sc  out  3  sequence counter T0..T6.
- instr_done  out  1  high in the last cycle of each instruction.
- halted  out  1  HLT executed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: sc=0, halted=0, latched opcode/I cleared.
  - While rst=1, every strobe is 0, opsel=010 and bus_sel=0.
  - Reset mid-instruction aborts it; the first cycle after rst falls is T0.
- Strobes and opsel are combinational from sc, latched decode, ir and flags.
- sc increments each cycle. When an instruction finishes, instr_done=1 and sc returns to 0 on the next edge.
- Default opsel is 010; opsel is meaningful only with ac_ld.
- Fetch:
  - T0: bus_sel=PC, ar_ld.
  - T1: mem_rd, bus_sel=MEM, ir_ld, pc_inc.
  - T2: bus_sel=IR, ar_ld; latch D=ir[14:12] and I=ir[15].
- T3:
  - D!=7 and I=1 (indirect): mem_rd, bus_sel=MEM, ar_ld.
  - D!=7 and I=0: idle.
  - D=7, I=0: register-reference instruction, completes at T3.
  - D=7, I=1: I/O, treated as a NOP, completes at T3.
- Memory-reference instructions, T4 onward:
  - AND(0): T4 DR<-M (mem_rd, MEM, dr_ld). T5 ac_ld, opsel=001, done.
  - ADD(1): T4 DR<-M. T5 ac_ld, opsel=000, e_set=(cntrl_e==10), e_clr=(cntrl_e==01), done.
  - LDA(2): T4 DR<-M. T5 ac_ld, opsel=010, done.
  - STA(3): T4 bus_sel=AC, mem_wr, done.
  - BUN(4): T4 bus_sel=AR, pc_ld, done.
  - BSA(5): T4 bus_sel=PC, mem_wr, ar_inc. T5 bus_sel=AR, pc_ld, done.
  - ISZ(6): T4 DR<-M. T5 dr_inc. T6 bus_sel=DR, mem_wr, pc_inc if dr_z, done.
- Register-reference instructions (T3):
  - Only the highest set bit of ir[11:0] executes; ir[11:0]==0 is a NOP.
  - b11 CLA: ac_clr.
  - b10 CLE: e_clr.
  - b9 CMA: ac_ld, opsel=011.
  - b8 CME: e_cmp.
  - b7 CIR: ac_ld, opsel=100, E set/clear per cntrl_e.
  - b6 CIL: ac_ld, opsel=101, E set/clear per cntrl_e.
  - b5 INC: ac_inc.
  - b4 SPA: pc_inc if !ac_n.
  - b3 SNA: pc_inc if ac_n.
  - b2 SZA: pc_inc if ac_z.
  - b1 SZE: pc_inc if !e.
  - b0 HLT: halted<=1.
- Halt: once halted=1, sc holds 0 and all strobes stay 0 until rst.
- Invariants:
  - At most one of e_set/e_clr/e_cmp is asserted.
  - mem_rd and mem_wr are never asserted together.

Decomposition:
- Package bc_pkg holds:
  - opsel constants (ALU_ADD..ALU_SHL);
  - bus_sel codes;
  - opcode constants (OP_AND..OP_ISZ, OP_RIO=7);
  - register-reference bit indices.
- Sub-module bc_seq_counter: 3-bit sc with inc/clr/hold; outputs one-hot t[6:0].

Test Plan:
- rst held for 2 cycles, then released with ir=16'h2010 (LDA direct) -> sc runs 0..5; T4 mem_rd+dr_ld; T5 ac_ld with opsel=010 and instr_done=1; next cycle sc=0.
- ADD (ir=16'h1020) with cntrl_e=10 at T5 -> ac_ld, opsel=000, e_set=1, e_clr=0. Repeat with cntrl_e=01 -> e_clr=1.
- ISZ (ir=16'h6030), dr_z=1 at T6 -> mem_wr, bus_sel=3, pc_inc=1. With dr_z=0 at T6 -> pc_inc=0.
- BUN indirect (ir=16'hC040) -> T3 mem_rd+ar_ld; T4 pc_ld with bus_sel=1; done at T4.
- Register-reference ir=16'h7041 (CIL+HLT) -> only CIL executes (opsel=101, ac_ld). Then ir=16'h7001 -> halted=1 and no strobes for 10 cycles; rst -> halted=0.
- rst asserted at T5 of BSA -> no pc_ld that cycle; next fetch starts at T0.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared encodings for the basic-computer control unit: ALU selects, bus sources,
// opcodes, register-reference bit positions and the run/halt state type.
package bc_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_AND = 3'b001;
   localparam logic [2:0] ALU_PDR = 3'b010;
   localparam logic [2:0] ALU_CMA = 3'b011;
   localparam logic [2:0] ALU_SHR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_RIO = 3'd7;

   localparam logic [3:0] RR_CLA  = 4'd11;
   localparam logic [3:0] RR_CLE  = 4'd10;
   localparam logic [3:0] RR_CMA  = 4'd9;
   localparam logic [3:0] RR_CME  = 4'd8;
   localparam logic [3:0] RR_CIR  = 4'd7;
   localparam logic [3:0] RR_CIL  = 4'd6;
   localparam logic [3:0] RR_INC  = 4'd5;
   localparam logic [3:0] RR_SPA  = 4'd4;
   localparam logic [3:0] RR_SNA  = 4'd3;
   localparam logic [3:0] RR_SZA  = 4'd2;
   localparam logic [3:0] RR_SZE  = 4'd1;
   localparam logic [3:0] RR_HLT  = 4'd0;
   localparam logic [3:0] RR_NONE = 4'd15;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } ctl_state_e;

   // Index of the highest set register-reference bit; RR_NONE when no bit is set.
   function automatic logic [3:0] rr_select(input logic [11:0] bits);
      logic [3:0] sel;
      sel = RR_NONE;
      for (int b = 0; b < 12; b++) begin
         if (bits[b]) sel = 4'(b);
      end
      return sel;
   endfunction

endpackage

// File: rtl/bc_seq_counter.sv
// Sequence counter: 3-bit timing count with clear/increment/hold and a one-hot
// decode of T0..T6.
module bc_seq_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_i,
   input  logic       clr_i,
   output logic [2:0] sc_o,
   output logic [6:0] t_o
);

   logic [2:0] sc_q;
   logic [2:0] sc_d;

   always_comb begin
      sc_d = sc_q;
      if (clr_i)      sc_d = 3'd0;
      else if (inc_i) sc_d = sc_q + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) sc_q <= 3'd0;
      else     sc_q <= sc_d;
   end

   assign sc_o = sc_q;
   assign t_o  = 7'd1 << sc_q;

endmodule

// File: rtl/bc_control_unit.sv
// Timing-and-control sequencer for the 16-bit basic computer: fetch, decode,
// indirect and execute strobes derived from the sequence count and latched decode.
//
// state   | meaning
// ST_RUN  | sequencing instructions, sc advances every cycle
// ST_HALT | HLT executed; sc held at 0, all strobes low until rst
module bc_control_unit
   import bc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ir,
   input  logic             ac_n,
   input  logic             ac_z,
   input  logic             dr_z,
   input  logic             e,
   input  logic [1:0]       cntrl_e,
   output logic [2:0]       opsel,
   output logic [2:0]       bus_sel,
   output logic             ar_ld,
   output logic             ar_inc,
   output logic             pc_ld,
   output logic             pc_inc,
   output logic             dr_ld,
   output logic             dr_inc,
   output logic             ac_ld,
   output logic             ac_clr,
   output logic             ac_inc,
   output logic             ir_ld,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             e_set,
   output logic             e_clr,
   output logic             e_cmp,
   output logic [2:0]       sc,
   output logic             instr_done,
   output logic             halted
);

   ctl_state_e state_q, state_d;
   logic [2:0] opc_q, opc_d;
   logic       ind_q, ind_d;
   logic [6:0] t;
   logic       run;
   logic       e_want_set, e_want_clr;

   bc_seq_counter u_seq (
      .clk   (clk),
      .rst   (rst),
      .inc_i (state_q == ST_RUN),
      .clr_i (instr_done || (state_q == ST_HALT)),
      .sc_o  (sc),
      .t_o   (t)
   );

   assign run        = !rst && (state_q == ST_RUN);
   assign e_want_set = (cntrl_e == 2'b10);
   assign e_want_clr = (cntrl_e == 2'b01);
   assign halted     = (state_q == ST_HALT);

   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      ind_d      = ind_q;
      opsel      = ALU_PDR;
      bus_sel    = BUS_NONE;
      ar_ld      = 1'b0;
      ar_inc     = 1'b0;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      dr_ld      = 1'b0;
      dr_inc     = 1'b0;
      ac_ld      = 1'b0;
      ac_clr     = 1'b0;
      ac_inc     = 1'b0;
      ir_ld      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      e_set      = 1'b0;
      e_clr      = 1'b0;
      e_cmp      = 1'b0;
      instr_done = 1'b0;

      if (run) begin
         if (t[0]) begin
            bus_sel = BUS_PC;
            ar_ld   = 1'b1;
         end
         if (t[1]) begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
         end
         if (t[2]) begin
            bus_sel = BUS_IR;
            ar_ld   = 1'b1;
            opc_d   = ir[WIDTH-2:WIDTH-4];
            ind_d   = ir[WIDTH-1];
         end
         if (t[3]) begin
            if (opc_q != OP_RIO) begin
               if (ind_q) begin
                  mem_rd  = 1'b1;
                  bus_sel = BUS_MEM;
                  ar_ld   = 1'b1;
               end
            end else begin
               instr_done = 1'b1;
               // I=1 with opcode 7 is I/O, which this machine treats as a NOP.
               if (!ind_q) begin
                  case (rr_select(ir[11:0]))
                     RR_CLA: ac_clr = 1'b1;
                     RR_CLE: e_clr  = 1'b1;
                     RR_CMA: begin ac_ld = 1'b1; opsel = ALU_CMA; end
                     RR_CME: e_cmp  = 1'b1;
                     RR_CIR: begin
                        ac_ld = 1'b1;
                        opsel = ALU_SHR;
                        e_set = e_want_set;
                        e_clr = e_want_clr;
                     end
                     RR_CIL: begin
                        ac_ld = 1'b1;
                        opsel = ALU_SHL;
                        e_set = e_want_set;
                        e_clr = e_want_clr;
                     end
                     RR_INC: ac_inc = 1'b1;
                     RR_SPA: pc_inc = !ac_n;
                     RR_SNA: pc_inc = ac_n;
                     RR_SZA: pc_inc = ac_z;
                     RR_SZE: pc_inc = !e;
                     RR_HLT: state_d = ST_HALT;
                     default: ;
                  endcase
               end
            end
         end
         if (t[4]) begin
            case (opc_q)
               OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                  mem_rd  = 1'b1;
                  bus_sel = BUS_MEM;
                  dr_ld   = 1'b1;
               end
               OP_STA: begin bus_sel = BUS_AC; mem_wr = 1'b1; instr_done = 1'b1; end
               OP_BUN: begin bus_sel = BUS_AR; pc_ld  = 1'b1; instr_done = 1'b1; end
               OP_BSA: begin bus_sel = BUS_PC; mem_wr = 1'b1; ar_inc = 1'b1; end
               default: ;
            endcase
         end
         if (t[5]) begin
            case (opc_q)
               OP_AND: begin ac_ld = 1'b1; opsel = ALU_AND; instr_done = 1'b1; end
               OP_ADD: begin
                  ac_ld      = 1'b1;
                  opsel      = ALU_ADD;
                  e_set      = e_want_set;
                  e_clr      = e_want_clr;
                  instr_done = 1'b1;
               end
               OP_LDA: begin ac_ld = 1'b1; opsel = ALU_PDR; instr_done = 1'b1; end
               OP_BSA: begin bus_sel = BUS_AR; pc_ld = 1'b1; instr_done = 1'b1; end
               OP_ISZ: dr_inc = 1'b1;
               default: ;
            endcase
         end
         if (t[6] && (opc_q == OP_ISZ)) begin
            bus_sel    = BUS_DR;
            mem_wr     = 1'b1;
            pc_inc     = dr_z;
            instr_done = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         opc_q   <= 3'd0;
         ind_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         ind_q   <= ind_d;
      end
   end

endmodule
